// File: rtl/bcd_to_binary_seq_if.sv
// rtl/bcd_to_binary_seq_if.sv - start/done handshake bundle for the BCD-to-binary decoder
interface bcd_to_binary_seq_if #(
  parameter int DIGITS = 3,
  parameter int BIN_W  = 8
);
  logic                  start;
  logic [4*DIGITS-1:0]   bcd_in;
  logic                  busy;
  logic                  done;
  logic [BIN_W-1:0]      bin_out;
  logic                  overflow;
  logic                  invalid;

  modport master (
    output start, bcd_in,
    input  busy, done, bin_out, overflow, invalid
  );

  modport slave (
    input  start, bcd_in,
    output busy, done, bin_out, overflow, invalid
  );
endinterface

// File: rtl/bcd_to_binary_seq.sv
// rtl/bcd_to_binary_seq.sv - sequential BCD-to-binary decoder (reverse double-dabble)
module bcd_to_binary_seq #(
  parameter int DIGITS = 3,
  parameter int BIN_W  = 8
) (
  input  logic                 mclk,
  input  logic                 reset_n,
  bcd_to_binary_seq_if.slave   bus
);
  localparam int BCD_W  = 4 * DIGITS;
  localparam int WORK_W = BCD_W + BIN_W;
  localparam int CNT_W  = $clog2(BIN_W + 1);

  typedef enum logic [1:0] {S_IDLE, S_SHIFT, S_FINISH} state_t;

  state_t              r_state;
  logic [WORK_W-1:0]   r_work;
  logic [CNT_W-1:0]    r_cnt;
  logic                r_err_inv;
  logic                r_busy;
  logic                r_done;
  logic [BIN_W-1:0]    r_bin;
  logic                r_ovf;
  logic                r_inv;

  logic [WORK_W-1:0]   w_shift;
  logic [WORK_W-1:0]   w_step;
  logic                w_bad;

  // One iteration: shift right, then pull every BCD nibble that reached 8+ back by 3.
  always_comb begin
    w_shift = r_work >> 1;
    w_step  = w_shift;
    for (int d = 0; d < DIGITS; d++) begin
      if (w_shift[BIN_W+4*d +: 4] >= 4'd8)
        w_step[BIN_W+4*d +: 4] = w_shift[BIN_W+4*d +: 4] - 4'd3;
    end
  end

  always_comb begin
    w_bad = 1'b0;
    for (int d = 0; d < DIGITS; d++) begin
      if (bus.bcd_in[4*d +: 4] > 4'd9)
        w_bad = 1'b1;
    end
  end

  always_ff @(posedge mclk or negedge reset_n) begin
    if (!reset_n) begin
      r_state   <= S_IDLE;
      r_work    <= '0;
      r_cnt     <= '0;
      r_err_inv <= 1'b0;
      r_busy    <= 1'b0;
      r_done    <= 1'b0;
      r_bin     <= '0;
      r_ovf     <= 1'b0;
      r_inv     <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (bus.start) begin
            r_work    <= {bus.bcd_in, {BIN_W{1'b0}}};
            r_cnt     <= '0;
            r_err_inv <= w_bad;
            r_busy    <= 1'b1;
            r_bin     <= '0;
            r_ovf     <= 1'b0;
            r_inv     <= 1'b0;
            r_state   <= w_bad ? S_FINISH : S_SHIFT;
          end
        end
        S_SHIFT: begin
          r_work <= w_step;
          r_cnt  <= r_cnt + 1'b1;
          if (r_cnt == CNT_W'(BIN_W - 1))
            r_state <= S_FINISH;
        end
        S_FINISH: begin
          if (r_err_inv) begin
            r_bin <= '0;
            r_inv <= 1'b1;
            r_ovf <= 1'b0;
          end else if (r_work[WORK_W-1:BIN_W] != '0) begin
            // Anything left in the BCD part means the value exceeded BIN_W bits.
            r_bin <= '1;
            r_ovf <= 1'b1;
          end else begin
            r_bin <= r_work[BIN_W-1:0];
          end
          r_done  <= 1'b1;
          r_busy  <= 1'b0;
          r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign bus.busy     = r_busy;
  assign bus.done     = r_done;
  assign bus.bin_out  = r_bin;
  assign bus.overflow = r_ovf;
  assign bus.invalid  = r_inv;
endmodule

// File: tb/tb_bcd_to_binary_seq.sv
// tb/tb_bcd_to_binary_seq.sv - scoreboard bench for the BCD-to-binary decoder
module tb_bcd_to_binary_seq;
  localparam int DIGITS = 3;
  localparam int BIN_W  = 8;

  typedef struct {
    logic [11:0] bcd;
    logic [7:0]  bin;
    logic        ovf;
    logic        inv;
  } exp_t;

  logic mclk;
  logic reset_n;
  exp_t sb[$];
  int   n_chk;
  int   n_pass;

  bcd_to_binary_seq_if #(.DIGITS(DIGITS), .BIN_W(BIN_W)) bus ();

  bcd_to_binary_seq #(.DIGITS(DIGITS), .BIN_W(BIN_W)) dut (
    .mclk    (mclk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  initial mclk = 1'b0;
  always #5 mclk = ~mclk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs === exp)
      n_pass++;
    else
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
  endtask

  function automatic exp_t model(input logic [11:0] bcd);
    exp_t e;
    int   val;
    e.bcd = bcd;
    e.inv = (bcd[11:8] > 4'd9) || (bcd[7:4] > 4'd9) || (bcd[3:0] > 4'd9);
    val   = int'(bcd[11:8]) * 100 + int'(bcd[7:4]) * 10 + int'(bcd[3:0]);
    e.ovf = 1'b0;
    e.bin = 8'h00;
    if (!e.inv) begin
      if (val > 255) begin
        e.ovf = 1'b1;
        e.bin = 8'hFF;
      end else begin
        e.bin = 8'(val);
      end
    end
    return e;
  endfunction

  function automatic logic [11:0] to_bcd(input int v);
    logic [11:0] b;
    b[11:8] = 4'(v / 100);
    b[7:4]  = 4'((v / 10) % 10);
    b[3:0]  = 4'(v % 10);
    return b;
  endfunction

  // Result checker: every done pulse consumes one expected entry.
  always @(negedge mclk) begin
    if (bus.done) begin
      if (sb.size() == 0) begin
        check("spurious_done", 32'(bus.done), 32'd0);
      end else begin
        exp_t e;
        e = sb.pop_front();
        check($sformatf("bin_%03h", e.bcd), 32'(bus.bin_out), 32'(e.bin));
        check($sformatf("ovf_%03h", e.bcd), 32'(bus.overflow), 32'(e.ovf));
        check($sformatf("inv_%03h", e.bcd), 32'(bus.invalid), 32'(e.inv));
      end
    end
  end

  task automatic do_conv(input logic [11:0] bcd, input bit timing, input bit toggle);
    exp_t e;
    int   n;
    bit   busy_ok;
    e = model(bcd);
    sb.push_back(e);
    @(negedge mclk);
    bus.start  = 1'b1;
    bus.bcd_in = bcd;
    @(negedge mclk);
    bus.start  = 1'b0;
    bus.bcd_in = 12'($urandom);
    busy_ok = (bus.busy === 1'b1);
    n = 0;
    while (n < 40) begin
      if (toggle && n < 5) begin
        bus.start  = 1'($urandom);
        bus.bcd_in = 12'($urandom);
      end else begin
        bus.start = 1'b0;
      end
      @(negedge mclk);
      n++;
      if (bus.done) break;
      if (bus.busy !== 1'b1) busy_ok = 1'b0;
    end
    bus.start = 1'b0;
    if (timing) begin
      check($sformatf("latency_%03h", bcd), 32'(n), e.inv ? 32'd1 : 32'(BIN_W + 1));
      check($sformatf("busy_hold_%03h", bcd), 32'(busy_ok), 32'd1);
      check($sformatf("busy_low_at_done_%03h", bcd), 32'(bus.busy), 32'd0);
    end else if (n >= 40) begin
      check($sformatf("timeout_%03h", bcd), 32'(n), 32'd0);
    end
  endtask

  initial begin
    n_chk      = 0;
    n_pass     = 0;
    reset_n    = 1'b0;
    bus.start  = 1'b0;
    bus.bcd_in = '0;
    repeat (3) @(negedge mclk);
    check("rst_busy", 32'(bus.busy), 32'd0);
    check("rst_done", 32'(bus.done), 32'd0);
    check("rst_bin", 32'(bus.bin_out), 32'd0);
    check("rst_flags", {30'd0, bus.overflow, bus.invalid}, 32'd0);
    reset_n = 1'b1;

    do_conv(12'h255, 1'b1, 1'b0);
    do_conv(12'h000, 1'b1, 1'b0);
    do_conv(12'h100, 1'b0, 1'b0);
    do_conv(12'h009, 1'b0, 1'b0);
    do_conv(12'h256, 1'b1, 1'b0);
    do_conv(12'h999, 1'b0, 1'b0);
    do_conv(12'h1A3, 1'b1, 1'b0);
    do_conv(12'h042, 1'b1, 1'b0);
    do_conv(12'h123, 1'b1, 1'b1);

    // Abandon a conversion with reset at the fourth edge after acceptance.
    @(negedge mclk);
    bus.start  = 1'b1;
    bus.bcd_in = 12'h200;
    @(negedge mclk);
    bus.start = 1'b0;
    repeat (3) @(negedge mclk);
    reset_n = 1'b0;
    #1;
    check("midrst_busy", 32'(bus.busy), 32'd0);
    check("midrst_done", 32'(bus.done), 32'd0);
    check("midrst_bin", 32'(bus.bin_out), 32'd0);
    check("midrst_flags", {30'd0, bus.overflow, bus.invalid}, 32'd0);
    repeat (3) @(negedge mclk);
    reset_n = 1'b1;
    repeat (12) @(negedge mclk);
    check("midrst_still_idle", 32'(bus.busy), 32'd0);

    do_conv(12'h087, 1'b1, 1'b0);

    for (int v = 0; v < 256; v++)
      do_conv(to_bcd(v), 1'b0, 1'b0);

    repeat (2) @(negedge mclk);
    check("sb_empty", 32'(sb.size()), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
